// File: rtl/pattern_pkg.sv
// Shared constants and loader state encoding for the pattern buffer and its serial loader.
// Buffer geometry here must match the pattern buffer instance.
package pattern_pkg;

   localparam int PB_WIDTH = 8;
   localparam int PB_SIZE  = 32;
   localparam int PB_BITS  = PB_WIDTH * PB_SIZE;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } loader_state_t;

endpackage

// File: rtl/pattern_loader_serdes_byte.sv
// One-byte serializer/deserializer: parallel load, MSB-first shift out, LSB-side capture in.
// Latency: byte shifted out and captured over WIDTH shift cycles; no backpressure, shift is caller-gated.
module serdes_byte
   import pattern_pkg::*;
#(
   parameter int WIDTH = PB_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             shift,
   input  logic [WIDTH-1:0] par_in,
   input  logic             ser_in,
   output logic             ser_out,
   output logic             last,
   output logic [WIDTH-1:0] par_out
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   logic [WIDTH-1:0] sreg;
   logic [WIDTH-1:0] rsreg;
   logic [CW-1:0]    bit_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sreg    <= '0;
         rsreg   <= '0;
         bit_cnt <= '0;
      end else if (load) begin
         sreg    <= par_in;
         bit_cnt <= '0;
      end else if (shift) begin
         sreg    <= sreg << 1;
         rsreg   <= {rsreg[WIDTH-2:0], ser_in};
         bit_cnt <= bit_cnt + CW'(1);
      end
   end

   assign ser_out = sreg[WIDTH-1];
   assign last    = shift && (bit_cnt == CW'(WIDTH - 1));
   // Includes the bit being sampled this cycle so the byte is complete on the last shift.
   assign par_out = {rsreg[WIDTH-2:0], ser_in};

endmodule

// File: rtl/pattern_loader.sv
// Streams a full image into the pattern buffer serial chain while returning the old image bytes.
// Latency: handshake n -> ssel n+1..n+WIDTH, rd_valid n+WIDTH+1; load_valid low stalls in FETCH with ssel low.
module pattern_loader
   import pattern_pkg::*;
#(
   parameter int BUFFER_WIDTH = PB_WIDTH,
   parameter int BUFFER_SIZE  = PB_SIZE
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [BUFFER_WIDTH-1:0] load_data,
   input  logic                    load_valid,
   output logic                    load_ready,
   output logic                    ssel,
   output logic                    sin,
   input  logic                    sout,
   output logic [BUFFER_WIDTH-1:0] rd_data,
   output logic                    rd_valid,
   output logic                    busy,
   output logic                    done
);

   localparam int BCW = $clog2(BUFFER_SIZE) + 1;

   loader_state_t         state_q;
   loader_state_t         state_d;
   logic [BCW-1:0]        byte_cnt;
   logic [BCW-1:0]        byte_cnt_nxt;
   logic                  fetch_hs;
   logic                  shift_en;
   logic                  byte_last;
   logic [BUFFER_WIDTH-1:0] byte_rd;

   assign fetch_hs     = (state_q == FETCH) && load_valid;
   assign shift_en     = (state_q == SHIFT);
   assign byte_cnt_nxt = byte_cnt + BCW'(1);

   serdes_byte #(
      .WIDTH (BUFFER_WIDTH)
   ) u_serdes (
      .clk     (clk),
      .rst     (rst),
      .load    (fetch_hs),
      .shift   (shift_en),
      .par_in  (load_data),
      .ser_in  (sout),
      .ser_out (sin),
      .last    (byte_last),
      .par_out (byte_rd)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = FETCH;
         FETCH:   if (load_valid) state_d = SHIFT;
         SHIFT: begin
            if (byte_last) begin
               state_d = (byte_cnt_nxt == BCW'(BUFFER_SIZE)) ? DONE : FETCH;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         byte_cnt <= '0;
         rd_data  <= '0;
         rd_valid <= 1'b0;
      end else begin
         rd_valid <= 1'b0;
         if (state_q == IDLE) begin
            byte_cnt <= '0;
         end else if (byte_last) begin
            byte_cnt <= byte_cnt_nxt;
            rd_data  <= byte_rd;
            rd_valid <= 1'b1;
         end
      end
   end

   // Outputs decode from state only; sin comes straight from the serializer flop.
   assign ssel       = (state_q == SHIFT);
   assign load_ready = (state_q == FETCH);
   assign busy       = (state_q != IDLE);
   assign done       = (state_q == DONE);

endmodule

// File: tb/tb_pattern_loader.sv
// Bench for pattern_loader: behavioural 8x32 serial buffer, random images, image-level readback model.
module tb_pattern_loader;

   localparam int W = 8;
   localparam int N = 32;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         start = 1'b0;
   logic [W-1:0] load_data = '0;
   logic         load_valid = 1'b0;
   logic         load_ready;
   logic         ssel;
   logic         sin;
   logic         sout;
   logic [W-1:0] rd_data;
   logic         rd_valid;
   logic         busy;
   logic         done;

   always #5 clk = ~clk;

   pattern_loader #(.BUFFER_WIDTH(W), .BUFFER_SIZE(N)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .load_data  (load_data),
      .load_valid (load_valid),
      .load_ready (load_ready),
      .ssel       (ssel),
      .sin        (sin),
      .sout       (sout),
      .rd_data    (rd_data),
      .rd_valid   (rd_valid),
      .busy       (busy),
      .done       (done)
   );

   // Pattern buffer as one chain: pattern[i] = buf_vec[i*W +: W], sout is bit 7 of the last byte.
   logic [W*N-1:0] buf_vec = '0;
   assign sout = buf_vec[W*N-1];
   always @(posedge clk) if (ssel) buf_vec <= {buf_vec[W*N-2:0], sin};

   int checks = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   int         cyc = 0;
   int         ssel_cnt, done_cnt, busy_gap, first_rv_cyc;
   bit         in_img = 0;
   bit         done_rv;
   logic [W-1:0] rd_q[$];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (!rst) begin
         if (ssel) ssel_cnt++;
         if (rd_valid) begin
            rd_q.push_back(rd_data);
            if (first_rv_cyc < 0) first_rv_cyc = cyc;
         end
         if (in_img && !busy) busy_gap++;
         if (done) begin
            done_cnt++;
            if (rd_valid) done_rv = 1;
            in_img = 0;
         end
      end
   end

   // Reference: an image loaded as byte sequence b[0..N-1] is read back in that same order next time.
   logic [W-1:0] img[N];
   logic [W-1:0] prev_img[N];
   bit           prev_known;
   bit           pend_b2b = 0;

   task automatic clear_stats();
      ssel_cnt = 0; done_cnt = 0; busy_gap = 0; first_rv_cyc = -1; done_rv = 0;
      rd_q.delete();
   endtask

   task automatic abort_run(input string tag);
      check(tag, 32'd0, 32'd1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "bound expired");
   endtask

   task automatic send_byte(input logic [W-1:0] b, output int hs);
      bit ok = 0;
      load_data  = b;
      load_valid = 1'b1;
      hs = -1;
      for (int t = 0; t < 100 && !ok; t++) begin
         @(negedge clk);
         if (load_ready) begin
            ok = 1;
            hs = cyc;
         end
         @(posedge clk); #1;
      end
      if (!ok) abort_run("handshake_timeout");
   endtask

   task automatic run_image(input int stall_at, input int mstart_at, input int rst_at,
                            input bit timed, input bit b2b_next);
      int  c, d, hs, hs0;
      bit  seen;
      clear_stats();
      if (pend_b2b) begin
         check("b2b_start_ignored_busy", busy, 1'b0);
         pend_b2b = 0;
      end else begin
         @(posedge clk); #1;
      end
      start = 1'b1;
      c = cyc;
      @(posedge clk); #1;
      start = 1'b0;
      in_img = 1;
      check("ready_after_start", load_ready, 1'b1);
      check("busy_after_start", busy, 1'b1);
      hs0 = -1;
      for (int k = 0; k < N; k++) begin
         if (k == stall_at) begin
            load_valid = 1'b0;
            seen = 0;
            for (int t = 0; t < 50 && !seen; t++) begin
               @(negedge clk);
               if (load_ready) seen = 1;
               else begin @(posedge clk); #1; end
            end
            if (!seen) abort_run("stall_fetch_timeout");
            for (int i = 0; i < 5; i++) begin
               if (i > 0) @(negedge clk);
               check($sformatf("stall_ssel_low[%0d]", i), ssel, 1'b0);
               @(posedge clk); #1;
            end
         end
         if (k == mstart_at) begin
            load_valid = 1'b0;
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
         end
         send_byte(img[k], hs);
         if (k == 0) hs0 = hs;
         if (k == rst_at) begin
            repeat (3) @(posedge clk);
            #1 rst = 1'b1;
            #1;
            check("rst_ssel", ssel, 1'b0);
            check("rst_busy", busy, 1'b0);
            check("rst_rd_valid", rd_valid, 1'b0);
            check("rst_load_ready", load_ready, 1'b0);
            check("rst_sin", sin, 1'b0);
            load_valid = 1'b0;
            in_img = 0;
            repeat (2) @(posedge clk);
            #1 rst = 1'b0;
            repeat (3) @(posedge clk); #1;
            check("rst_stays_idle", busy, 1'b0);
            check("rst_rd_count", rd_q.size(), rst_at);
            prev_known = 0;
            return;
         end
      end
      load_valid = 1'b0;
      seen = 0;
      d = -1;
      for (int t = 0; t < 3000 && !seen; t++) begin
         @(negedge clk);
         if (done) begin
            seen = 1;
            d = cyc;
            if (b2b_next) start = 1'b1;
         end
      end
      if (!seen) abort_run("done_timeout");
      @(posedge clk); #1;
      start = 1'b0;
      pend_b2b = b2b_next;
      check("shift_count", ssel_cnt, N * W);
      check("done_count", done_cnt, 1);
      check("busy_continuous", busy_gap, 0);
      check("last_rv_with_done", done_rv, 1'b1);
      check("rd_count", rd_q.size(), N);
      if (timed) begin
         check("done_latency", d - c, 1 + N * (W + 1));
         check("first_rv_latency", first_rv_cyc - hs0, W + 1);
      end
      if (prev_known && rd_q.size() == N)
         for (int k = 0; k < N; k++) check($sformatf("readback[%0d]", k), rd_q[k], prev_img[k]);
      for (int k = 0; k < N; k++)
         check($sformatf("buffer_pattern[%0d]", N - 1 - k), buf_vec[(N-1-k)*W +: W], img[k]);
      if (mstart_at >= 0) begin
         repeat (20) @(posedge clk); #1;
         check("mid_start_single_done", done_cnt, 1);
         check("mid_start_not_queued", busy, 1'b0);
      end
      prev_img   = img;
      prev_known = 1;
   endtask

   initial begin
      #2 rst = 1'b1;
      repeat (3) @(posedge clk); #1;
      check("reset_ssel", ssel, 1'b0);
      check("reset_sin", sin, 1'b0);
      check("reset_load_ready", load_ready, 1'b0);
      check("reset_rd_data", rd_data, '0);
      check("reset_rd_valid", rd_valid, 1'b0);
      check("reset_busy", busy, 1'b0);
      check("reset_done", done, 1'b0);
      rst = 1'b0;
      repeat (2) @(posedge clk); #1;
      check("idle_without_start", busy, 1'b0);
      for (int k = 0; k < N; k++) prev_img[k] = '0;
      prev_known = 1;

      for (int k = 0; k < N; k++) img[k] = W'(k);
      run_image(-1, -1, -1, 1, 0);
      for (int k = 0; k < N; k++) img[k] = W'(8'hFF - k);
      run_image(7, -1, -1, 0, 0);
      for (int k = 0; k < N; k++) img[k] = W'($urandom);
      run_image(-1, 12, -1, 0, 0);
      for (int k = 0; k < N; k++) img[k] = W'($urandom);
      run_image(-1, -1, 10, 0, 0);
      for (int k = 0; k < N; k++) img[k] = 8'hA5;
      run_image(-1, -1, -1, 1, 1);
      for (int r = 0; r < 3; r++) begin
         for (int k = 0; k < N; k++) img[k] = W'($urandom);
         if (r == 0) run_image(-1, -1, -1, 1, 0);
         else run_image($urandom_range(1, N - 1), -1, -1, 0, 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
